// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: NOP word, stage state encoding,
// default performance-counter width.
package pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'hFC00_0000;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_st_e;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready beat channel between pipeline stages.
// master drives the beat, slave drives back-pressure.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 32
);

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with increment enable.
// Holds at all-ones; clears on asynchronous active-low reset.
module pipe_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid-buffered pipeline stage register with flush and NOP fill.
// Optional stall/flush counters enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  NOP_VAL = DATA_W'(NOP_INST),
  parameter int                 CNT_W   = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_buf_if.slave       in_if,
  pipe_stage_buf_if.master      out_if,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
`endif
  output logic [1:0]            occupancy
);

  stage_st_e         state_q;
  stage_st_e         state_d;
  logic              main_vld_q;
  logic              main_vld_d;
  logic              skid_vld_q;
  logic              skid_vld_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              accept;
  logic              drain;

  // Handshake outputs come straight from valid flops, never from inputs.
  assign in_if.ready  = ~skid_vld_q;
  assign out_if.valid = main_vld_q;
  assign out_if.data  = main_vld_q ? main_q : NOP_VAL;
  assign occupancy    = {skid_vld_q, main_vld_q & ~skid_vld_q};

  assign accept = in_if.valid & ~skid_vld_q;
  assign drain  = main_vld_q & out_if.ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = HALF;
          main_d  = in_if.data;
        end
      end
      HALF: begin
        if (accept && drain) begin
          main_d = in_if.data;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_if.data;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d = HALF;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
    main_vld_d = (state_d != EMPTY);
    skid_vld_d = (state_d == FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Payload flops carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = main_vld_q & ~out_if.ready;
  assign flush_inc = flush & (state_q != EMPTY);

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf.
// Counter checks are compiled in with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_buf;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;
  int         errors;
  int         checks;

  pipe_stage_buf_if #(.DATA_W(32)) in_if ();
  pipe_stage_buf_if #(.DATA_W(32)) out_if ();

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [1:0]  stall_cnt2;
  logic [1:0]  flush_cnt2;
  logic [1:0]  occupancy2;
  pipe_stage_buf_if #(.DATA_W(32)) in2_if ();
  pipe_stage_buf_if #(.DATA_W(32)) out2_if ();
`endif

  pipe_stage_buf #(
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_if     (in_if),
    .out_if    (out_if),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .occupancy (occupancy)
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_buf #(
    .DATA_W (32),
    .CNT_W  (2)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_if     (in2_if),
    .out_if    (out2_if),
    .stall_cnt (stall_cnt2),
    .flush_cnt (flush_cnt2),
    .occupancy (occupancy2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] d);
    in_if.valid = v;
    in_if.data  = d;
`ifdef PIPE_STAGE_PERF_EN
    in2_if.valid = v;
    in2_if.data  = d;
`endif
  endtask

  task automatic drive_rdy(input logic r);
    out_if.ready = r;
`ifdef PIPE_STAGE_PERF_EN
    out2_if.ready = r;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    drive_in(1'b0, 32'h0);
    drive_rdy(1'b0);
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    drive_in(1'b1, 32'h1234_5678);
    drive_rdy(1'b0);
    step();
    step();
    checks += 4;
    if (out_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b want 0", out_if.valid);
    end
    if (out_if.data !== 32'hFC00_0000) begin
      errors++;
      $display("FAIL rst_data: got %h want fc000000", out_if.data);
    end
    if (in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1", in_if.ready);
    end
    if (occupancy !== 2'd0) begin
      errors++;
      $display("FAIL rst_occ: got %0d want 0", occupancy);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks += 2;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_stall: got %0d want 0", stall_cnt);
    end
    if (flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_flushcnt: got %0d want 0", flush_cnt);
    end
`endif
    drive_in(1'b0, 32'h0);
    rst = 1'b1;
    step();
  endtask

  task automatic test_stream();
    do_reset();
    drive_rdy(1'b1);
    for (int i = 1; i <= 8; i++) begin
      drive_in(1'b1, 32'(i));
      step();
      checks += 3;
      if (out_if.valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid[%0d]: got %b want 1", i, out_if.valid);
      end
      if (out_if.data !== 32'(i)) begin
        errors++;
        $display("FAIL stream_data[%0d]: got %h want %h", i, out_if.data, i);
      end
      if (occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy);
      end
    end
    drive_in(1'b0, 32'h0);
    step();
    checks++;
    if (out_if.valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL stream_end: got v=%b occ=%0d want v=0 occ=0", out_if.valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_rdy(1'b0);
    drive_in(1'b1, 32'hA);
    step();
    checks++;
    if (in_if.ready !== 1'b1 || occupancy !== 2'd1 || out_if.data !== 32'hA) begin
      errors++;
      $display("FAIL bp_a: got r=%b occ=%0d d=%h want r=1 occ=1 d=a", in_if.ready, occupancy, out_if.data);
    end
    drive_in(1'b1, 32'hB);
    step();
    checks++;
    if (in_if.ready !== 1'b0 || occupancy !== 2'd2) begin
      errors++;
      $display("FAIL bp_full: got r=%b occ=%0d want r=0 occ=2", in_if.ready, occupancy);
    end
    drive_in(1'b1, 32'hC);
    step();
    checks++;
    if (in_if.ready !== 1'b0 || occupancy !== 2'd2 || out_if.data !== 32'hA) begin
      errors++;
      $display("FAIL bp_hold: got r=%b occ=%0d d=%h want r=0 occ=2 d=a", in_if.ready, occupancy, out_if.data);
    end
    drive_rdy(1'b1);
    step();
    checks++;
    if (out_if.data !== 32'hB || occupancy !== 2'd1 || in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_b: got d=%h occ=%0d r=%b want d=b occ=1 r=1", out_if.data, occupancy, in_if.ready);
    end
    step();
    checks++;
    if (out_if.data !== 32'hC || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL bp_c: got d=%h occ=%0d want d=c occ=1", out_if.data, occupancy);
    end
    drive_in(1'b0, 32'h0);
    step();
    checks++;
    if (out_if.valid !== 1'b0 || out_if.data !== 32'hFC00_0000) begin
      errors++;
      $display("FAIL bp_drained: got v=%b d=%h want v=0 d=fc000000", out_if.valid, out_if.data);
    end
  endtask

  task automatic test_flush_full();
    do_reset();
    drive_rdy(1'b0);
    drive_in(1'b1, 32'h11);
    step();
    drive_in(1'b1, 32'h22);
    step();
    drive_in(1'b1, 32'hD);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks += 3;
    if (out_if.valid !== 1'b0 || out_if.data !== 32'hFC00_0000) begin
      errors++;
      $display("FAIL flush_out: got v=%b d=%h want v=0 d=fc000000", out_if.valid, out_if.data);
    end
    if (occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_occ: got %0d want 0", occupancy);
    end
    if (in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: got %b want 1", in_if.ready);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL flush_cnt_full: got %0d want 1", flush_cnt);
    end
`endif
    drive_in(1'b1, 32'hE);
    step();
    checks++;
    if (out_if.valid !== 1'b1 || out_if.data !== 32'hE || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL flush_refill: got v=%b d=%h occ=%0d want v=1 d=e occ=1", out_if.valid, out_if.data, occupancy);
    end
    drive_in(1'b0, 32'h0);
    drive_rdy(1'b1);
    step();
    checks++;
    if (out_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_noD: got v=%b d=%h want v=0", out_if.valid, out_if.data);
    end
  endtask

  task automatic test_flush_empty();
    do_reset();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_if.valid !== 1'b0 || occupancy !== 2'd0 || in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: got v=%b occ=%0d r=%b want v=0 occ=0 r=1", out_if.valid, occupancy, in_if.ready);
    end
`ifdef PIPE_STAGE_PERF_EN
    checks++;
    if (flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL flush_cnt_empty: got %0d want 0", flush_cnt);
    end
`endif
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    do_reset();
    drive_rdy(1'b0);
    drive_in(1'b1, 32'h55);
    step();
    drive_in(1'b0, 32'h0);
    repeat (5) step();
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stall_cnt5: got %0d want 5", stall_cnt);
    end
    step();
    checks += 2;
    if (stall_cnt !== 16'd6) begin
      errors++;
      $display("FAIL stall_cnt6: got %0d want 6", stall_cnt);
    end
    if (stall_cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL stall_sat: got %0d want 3", stall_cnt2);
    end
    drive_rdy(1'b1);
    step();
    checks++;
    if (stall_cnt !== 16'd6 || out_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got cnt=%0d v=%b want cnt=6 v=0", stall_cnt, out_if.valid);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    flush = 1'b0;
    drive_in(1'b0, 32'h0);
    drive_rdy(1'b0);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_empty();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register, successor to the fixed 32-bit IF/ID latch. It carries a DATA_W-bit payload between two pipeline stages using a valid/ready handshake and a two-entry skid buffer, so stalls propagate back without combinational ready paths. A synchronous flush squashes all held entries; the output presents a configurable NOP word whenever no valid entry is held. It is instantiated between IF/ID, ID/EX and later stages of the MIPS pipeline.

## Interface
- DATA_W, 32, payload width in bits
- NOP_VAL, pipe_pkg::NOP_INST (32'hFC00_0000, truncated/zero-extended to DATA_W), word driven on out_data when out_valid=0
- CNT_W, 16, width of performance counters (used only with PIPE_STAGE_PERF_EN)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream beat present
- in_data  input  DATA_W  upstream payload
- in_ready  output  1  stage can accept a beat this cycle
- out_valid  output  1  head entry valid
- out_data  output  DATA_W  head payload, or NOP_VAL when out_valid=0
- out_ready  input  1  downstream accepts head this cycle
- occupancy  output  2  entries held (0..2)
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0 (PIPE_STAGE_PERF_EN only)
- flush_cnt  output  CNT_W  flushes squashing at least one valid entry (PIPE_STAGE_PERF_EN only)

## Operation
- Storage: main entry (head, drives out_data) and skid entry, each with a valid bit.
- States: EMPTY (none valid), HALF (main valid), FULL (main and skid valid).
- in_ready = (state != FULL), taken directly from a register; out_valid = (state != EMPTY). Neither depends combinationally on the opposite-side inputs.
- Accept = in_valid & in_ready; Drain = out_valid & out_ready.
- EMPTY: Accept -> HALF, main <= in_data.
- HALF: Accept & Drain -> HALF, main <= in_data. Accept only -> FULL, skid <= in_data. Drain only -> EMPTY.
- FULL: Drain -> HALF, main <= skid. No Accept is possible in FULL.
- Order is strictly FIFO; a beat is never duplicated or dropped except on flush.
- flush has highest priority. At the next edge the state becomes EMPTY, both valid bits are cleared, and any simultaneous Accept is discarded. A Drain in the flush cycle still counts as delivered downstream.
- out_data = NOP_VAL whenever out_valid=0, including during reset.
- occupancy = 0/1/2 for EMPTY/HALF/FULL.
- Payload registers are not reset; valid bits and state are reset.

## Timing
- Reset (rst=0, asynchronous): state EMPTY, out_valid=0, out_data=NOP_VAL, in_ready=1, occupancy=0, counters=0. Reset applied mid-transfer loses all entries immediately.
- Latency: a beat accepted at edge N is visible on out_data after edge N (one cycle).
- Throughput: one beat per cycle with out_ready held at 1; no bubbles are inserted.
- Stall: after out_ready drops, up to one more beat is accepted (into skid); in_ready deasserts the cycle after FULL is reached.
- Flush: out_valid=0 and in_ready=1 in the cycle after the flush edge; upstream may refill on that same cycle.

## Configuration
- PIPE_STAGE_PERF_EN defined: stall_cnt and flush_cnt ports exist. Both counters are saturating at 2^CNT_W-1 and reset to 0. flush_cnt increments only when flush=1 and state != EMPTY.
- PIPE_STAGE_PERF_EN undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- pipe_pkg holds: NOP_INST constant (32'hFC00_0000), the stage state enum (EMPTY/HALF/FULL), and the default CNT_W.
- Sub-module pipe_perf_cnt: a saturating CNT_W-bit counter with an increment enable, instantiated twice under PIPE_STAGE_PERF_EN.

## Test plan
- Reset: hold rst=0 while driving in_valid=1 with 32'h1234_5678 -> out_valid=0, out_data=32'hFC00_0000, in_ready=1, occupancy=0.
- Streaming: 8 beats 1..8 with out_ready=1 -> out_data shows 1..8 on consecutive cycles, one cycle after each accept, with occupancy constant at 1.
- Backpressure: out_ready=0 while sending A, B, C -> A and B accepted, in_ready=0 with C held, occupancy=2. Raise out_ready -> A, B, C delivered in order, no loss.
- Flush when FULL with simultaneous in_valid=D -> next cycle out_valid=0, out_data=NOP_VAL, occupancy=0, D never appears; flush_cnt=1.
- Flush when EMPTY -> state unchanged; flush_cnt stays 0.
- PERF: out_ready=0 for 5 cycles with the head valid -> stall_cnt=5. With CNT_W=2 and 6 stall cycles -> stall_cnt saturates at 3.
